xt_lb_req_gate: RTL and testbench
=================================

# xt_lb_req_gate

HB-side request gate sitting directly upstream of the low-speed bus (LB) bridge, in the hb_clk domain. It decodes HB accesses that target the LB window and latches them into a stable request. It presents that request to the bridge as held `sel` strobes and stalls the HB master until the bridge's `finish` pulse returns. It then hands back read data, or a bus error on watchdog timeout.

## Interface
Parameters:
- LB_BASE, 32'h0000_8000: base address of the LB window.
- LB_MASK, 32'hFFFF_F000: address bits compared against LB_BASE; hit = (addr & LB_MASK) == LB_BASE.
- TIMEOUT_CYCLES, 255: WAIT cycles before a timeout error; legal range 1..65535.

Ports:
- hb_clk  in  1  HB clock.
- rst_sync  in  1  reset, asynchronous, active-high.
- hb_ren  in  1  HB read request.
- hb_wen  in  1  HB write request.
- hb_raddr  in  32  read address.
- hb_waddr  in  32  write address.
- hb_wdata  in  32  write data.
- hb_write_width  in  2  write width code, passed through unchanged.
- hb_stall  out  1  holds the HB master.
- hb_rdata  out  32  read data, valid with hb_resp_valid.
- hb_resp_valid  out  1  one-cycle completion pulse.
- hb_resp_err  out  1  timeout error, qualified by hb_resp_valid.
- lb_sel_ren  out  1  read strobe to the bridge.
- lb_sel_wen  out  1  write strobe to the bridge.
- lb_raddr  out  32  latched read address.
- lb_waddr  out  32  latched write address.
- lb_wdata  out  32  latched write data.
- lb_write_width  out  2  latched write width.
- lb_rdata  in  32  bridge read data.
- lb_finish  in  1  bridge completion pulse (single hb_clk cycle).

## Operation
States: IDLE, WAIT, RESP, DRAIN.

IDLE
- hit = (hb_ren & raddr hits) | (hb_wen & waddr hits).
- On hit:
  - latch ren/wen (each gated by its own address hit), raddr, waddr, wdata, write_width;
  - clear the watchdog counter;
  - go to WAIT.
- hb_stall is combinationally 1 in the hit cycle.
- Non-hit requests are ignored: no stall, no response.

WAIT
- lb_sel_ren = ren_q & ~lb_finish; lb_sel_wen = wen_q & ~lb_finish. The strobes are never high in the finish cycle, so the bridge cannot re-issue.
- Latched request fields are held constant.
- On lb_finish:
  - capture lb_rdata into hb_rdata (write-only requests also capture it; the value is don't-care to the master);
  - clear ren_q/wen_q;
  - go to RESP.
- On watchdog count == TIMEOUT_CYCLES without finish:
  - hb_rdata <= 0, err_q <= 1, clear ren_q/wen_q;
  - go to RESP.

RESP
- hb_resp_valid = 1, hb_resp_err = err_q, hb_stall = 0.
- Next state:
  - err_q set → DRAIN;
  - otherwise → IDLE.

DRAIN
- Waits for the late lb_finish of the abandoned transfer; its data is discarded.
- hb_stall = 1 if a hit request is presented.
- On lb_finish: clear err_q, go to IDLE.

Other rules
- lb_finish in IDLE or RESP is ignored.
- hb_stall = hit in IDLE | WAIT | (DRAIN & hit); it is 0 in RESP.

## Timing
- Reset values: state IDLE; all outputs 0; err_q 0; counter 0.
- Reset mid-transfer returns to IDLE immediately. No response is generated and the strobes drop asynchronously.
- Latency: hit cycle T0, strobes high from T0+1; finish at Tf; hb_resp_valid at Tf+1; master released at Tf+1.
- Simultaneous read and write hits are issued together. The bridge orders them read before write and returns a single finish.
- Watchdog counter:
  - width $clog2(TIMEOUT_CYCLES+1), unsigned;
  - increments each WAIT cycle;
  - saturates and never wraps.
- If finish and timeout coincide, finish wins: normal response, no error.

## Configuration
- XT_LB_TIMEOUT_EN defined: watchdog, timeout error path and DRAIN state are present.
- Not defined: no counter; WAIT waits indefinitely for lb_finish; hb_resp_err is tied to 0; DRAIN is unreachable and removed.

## Structure
- XT_LBUS_Pkg holds:
  - the lb_gate_state_e enum (2-bit, IDLE=0, WAIT=1, RESP=2, DRAIN=3);
  - default LB_BASE/LB_MASK constants;
  - an lb_req_t struct {ren, wen, raddr, waddr, wdata, write_width} used for the latch.
- One sub-module, xt_lb_watchdog: saturating counter with clear, enable and an expired output, compiled only under XT_LB_TIMEOUT_EN.

## Test plan
- Read 0x8004 in IDLE; bench asserts lb_finish 6 cycles later with lb_rdata=0xDEADBEEF → lb_sel_ren held 5 cycles and low in the finish cycle; hb_rdata=0xDEADBEEF, resp_valid 1 cycle, err=0.
- Write 0x8010 with wdata 0x1234_5678, width 2 → lb_waddr/lb_wdata/lb_write_width stable until finish; lb_sel_wen only; single response.
- Simultaneous read 0x8000 and write 0x8008, one finish → both strobes high together, one response.
- Read 0x4000 (miss) → no stall, no strobes, no response.
- XT_LB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no finish:
  - resp_valid with err=1 and rdata=0 after 8 WAIT cycles;
  - a new hit is stalled in DRAIN until a finish arrives;
  - that late data is discarded.
- Assert rst_sync mid-WAIT → outputs 0 immediately; next request handled normally.

Source files
------------

// File: rtl/xt_lb_req_gate_pkg.sv
// Shared types and defaults for the HB-side LB request gate.
package XT_LBUS_Pkg;

   typedef enum logic [1:0] {
      LB_IDLE  = 2'd0,
      LB_WAIT  = 2'd1,
      LB_RESP  = 2'd2,
      LB_DRAIN = 2'd3
   } lb_gate_state_e;

   localparam logic [31:0] LB_BASE_DEF = 32'h0000_8000;
   localparam logic [31:0] LB_MASK_DEF = 32'hFFFF_F000;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [1:0]  write_width;
   } lb_req_t;

   function automatic logic lb_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/xt_lb_req_gate_watchdog.sv
// Saturating WAIT-cycle counter; expired while the count equals MAX_COUNT.
module xt_lb_watchdog #(
   parameter int unsigned MAX_COUNT = 255
) (
   input  logic hb_clk,
   input  logic rst_sync,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned     CW   = $clog2(MAX_COUNT + 1);
   localparam logic [CW-1:0]   CMAX = CW'(MAX_COUNT);

   logic [CW-1:0] cnt;

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && (cnt != CMAX))
         cnt <= cnt + CW'(1);
   end

   assign expired = (cnt == CMAX);

endmodule

// File: rtl/xt_lb_req_gate.sv
// HB request gate in front of the LB bridge: latch, hold sel strobes, stall until finish.
// Define XT_LB_TIMEOUT_EN to add the watchdog, timeout error response and DRAIN state.
module xt_lb_req_gate
   import XT_LBUS_Pkg::*;
#(
   parameter logic [31:0]  LB_BASE        = LB_BASE_DEF,
   parameter logic [31:0]  LB_MASK        = LB_MASK_DEF,
   parameter int unsigned  TIMEOUT_CYCLES = 255
) (
   input  logic        hb_clk,
   input  logic        rst_sync,
   input  logic        hb_ren,
   input  logic        hb_wen,
   input  logic [31:0] hb_raddr,
   input  logic [31:0] hb_waddr,
   input  logic [31:0] hb_wdata,
   input  logic [1:0]  hb_write_width,
   output logic        hb_stall,
   output logic [31:0] hb_rdata,
   output logic        hb_resp_valid,
   output logic        hb_resp_err,
   output logic        lb_sel_ren,
   output logic        lb_sel_wen,
   output logic [31:0] lb_raddr,
   output logic [31:0] lb_waddr,
   output logic [31:0] lb_wdata,
   output logic [1:0]  lb_write_width,
   input  logic [31:0] lb_rdata,
   input  logic        lb_finish
);

   lb_gate_state_e state, state_nx;
   lb_req_t        req_q;
   logic           hit_r, hit_w, hit;
   logic           tmo;

   assign hit_r = hb_ren & lb_hit(hb_raddr, LB_BASE, LB_MASK);
   assign hit_w = hb_wen & lb_hit(hb_waddr, LB_BASE, LB_MASK);
   assign hit   = hit_r | hit_w;

`ifdef XT_LB_TIMEOUT_EN
   logic err_q;
   logic expired;

   xt_lb_watchdog #(.MAX_COUNT(TIMEOUT_CYCLES)) u_wdog (
      .hb_clk   (hb_clk),
      .rst_sync (rst_sync),
      .clr      ((state == LB_IDLE) && hit),
      .en       (state == LB_WAIT),
      .expired  (expired)
   );

   // finish takes priority over a coincident timeout
   assign tmo = expired & ~lb_finish;

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync)
         err_q <= 1'b0;
      else if ((state == LB_WAIT) && tmo)
         err_q <= 1'b1;
      else if ((state == LB_DRAIN) && lb_finish)
         err_q <= 1'b0;
   end

   assign hb_resp_err = hb_resp_valid & err_q;
`else
   logic unused_tmo;
   assign unused_tmo  = (TIMEOUT_CYCLES == 0);
   assign tmo         = 1'b0;
   assign hb_resp_err = 1'b0;
`endif

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         state    <= LB_IDLE;
         req_q    <= '0;
         hb_rdata <= '0;
      end else begin
         state <= state_nx;
         if ((state == LB_IDLE) && hit) begin
            req_q <= '{ren: hit_r, wen: hit_w, raddr: hb_raddr, waddr: hb_waddr,
                       wdata: hb_wdata, write_width: hb_write_width};
         end else if ((state == LB_WAIT) && (lb_finish || tmo)) begin
            req_q.ren <= 1'b0;
            req_q.wen <= 1'b0;
            hb_rdata  <= lb_finish ? lb_rdata : '0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      hb_stall = 1'b0;
      case (state)
         LB_IDLE: begin
            hb_stall = hit;
            if (hit) state_nx = LB_WAIT;
         end
         LB_WAIT: begin
            hb_stall = 1'b1;
            if (lb_finish || tmo) state_nx = LB_RESP;
         end
         LB_RESP: begin
`ifdef XT_LB_TIMEOUT_EN
            state_nx = err_q ? LB_DRAIN : LB_IDLE;
`else
            state_nx = LB_IDLE;
`endif
         end
`ifdef XT_LB_TIMEOUT_EN
         LB_DRAIN: begin
            hb_stall = hit;
            if (lb_finish) state_nx = LB_IDLE;
         end
`endif
         default: state_nx = LB_IDLE;
      endcase
   end

   assign hb_resp_valid  = (state == LB_RESP);
   assign lb_sel_ren     = (state == LB_WAIT) & req_q.ren & ~lb_finish;
   assign lb_sel_wen     = (state == LB_WAIT) & req_q.wen & ~lb_finish;
   assign lb_raddr       = req_q.raddr;
   assign lb_waddr       = req_q.waddr;
   assign lb_wdata       = req_q.wdata;
   assign lb_write_width = req_q.write_width;

endmodule

// File: tb/tb_xt_lb_req_gate.sv
// Self-checking bench for xt_lb_req_gate: directed scenarios plus randomized traffic vs. a transaction model.
module tb_xt_lb_req_gate;

`ifdef XT_LB_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 255;
`endif
   localparam logic [31:0] BASE = 32'h0000_8000;
   localparam logic [31:0] MASK = 32'hFFFF_F000;

   logic        hb_clk = 1'b0;
   logic        rst_sync;
   logic        hb_ren, hb_wen;
   logic [31:0] hb_raddr, hb_waddr, hb_wdata;
   logic [1:0]  hb_write_width;
   logic        hb_stall;
   logic [31:0] hb_rdata;
   logic        hb_resp_valid, hb_resp_err;
   logic        lb_sel_ren, lb_sel_wen;
   logic [31:0] lb_raddr, lb_waddr, lb_wdata;
   logic [1:0]  lb_write_width;
   logic [31:0] lb_rdata;
   logic        lb_finish;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   xt_lb_req_gate #(.LB_BASE(BASE), .LB_MASK(MASK), .TIMEOUT_CYCLES(TMO)) dut (
      .hb_clk(hb_clk), .rst_sync(rst_sync), .hb_ren(hb_ren), .hb_wen(hb_wen),
      .hb_raddr(hb_raddr), .hb_waddr(hb_waddr), .hb_wdata(hb_wdata),
      .hb_write_width(hb_write_width), .hb_stall(hb_stall), .hb_rdata(hb_rdata),
      .hb_resp_valid(hb_resp_valid), .hb_resp_err(hb_resp_err),
      .lb_sel_ren(lb_sel_ren), .lb_sel_wen(lb_sel_wen), .lb_raddr(lb_raddr),
      .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_write_width(lb_write_width),
      .lb_rdata(lb_rdata), .lb_finish(lb_finish)
   );

   always #5 hb_clk = ~hb_clk;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [1:0]  width;
      int unsigned dly;
      logic [31:0] rdata;
   } xfer_t;

   function automatic logic in_win(input logic [31:0] a);
      return (a & MASK) == BASE;
   endfunction

   task automatic tick;
      @(posedge hb_clk);
      #1;
   endtask

   task automatic clear_inputs;
      hb_ren = 1'b0; hb_wen = 1'b0;
      hb_raddr = '0; hb_waddr = '0; hb_wdata = '0; hb_write_width = '0;
      lb_finish = 1'b0; lb_rdata = '0;
   endtask

   task automatic test_reset;
      repeat (2) tick;
      n_cmp++;
      if ({hb_stall, hb_rdata, hb_resp_valid, hb_resp_err, lb_sel_ren, lb_sel_wen,
           lb_raddr, lb_waddr, lb_wdata, lb_write_width} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got stall=%b rdata=%h v=%b e=%b sel=%b%b want all 0",
                  hb_stall, hb_rdata, hb_resp_valid, hb_resp_err, lb_sel_ren, lb_sel_wen);
      end
      @(negedge hb_clk);
      rst_sync = 1'b0;
   endtask

   task automatic test_directed;
      xfer_t tbl[4];
      tbl[0] = '{1'b1, 1'b0, 32'h0000_8004, 32'h0,         32'h0,         2'd0, 6, 32'hDEAD_BEEF};
      tbl[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_8010, 32'h1234_5678, 2'd2, 4, 32'hA5A5_A5A5};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_8000, 32'h0000_8008, 32'hCAFE_F00D, 2'd1, 3, 32'h0102_0304};
      tbl[3] = '{1'b1, 1'b0, 32'h0000_8FFC, 32'h0,         32'h0,         2'd3, 1, 32'h55AA_55AA};
      foreach (tbl[i]) begin
         tick;
         hb_ren = tbl[i].ren; hb_wen = tbl[i].wen;
         hb_raddr = tbl[i].raddr; hb_waddr = tbl[i].waddr;
         hb_wdata = tbl[i].wdata; hb_write_width = tbl[i].width;
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_stall, lb_sel_ren, lb_sel_wen} !== 3'b100) begin
            n_bad++;
            $display("FAIL dir%0d_hit_cycle: got stall/sel=%b want 100", i, {hb_stall, lb_sel_ren, lb_sel_wen});
         end
         for (int unsigned k = 1; k < tbl[i].dly; k++) begin
            tick;
            hb_ren = 1'b0; hb_wen = 1'b0;
            hb_raddr = $urandom; hb_waddr = $urandom; hb_wdata = $urandom;
            hb_write_width = 2'($urandom);
            @(negedge hb_clk);
            n_cmp++;
            if ({hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen} !== {1'b1, 1'b0, tbl[i].ren, tbl[i].wen}) begin
               n_bad++;
               $display("FAIL dir%0d_wait%0d: got stall/v/sel=%b want %b", i, k,
                        {hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen},
                        {1'b1, 1'b0, tbl[i].ren, tbl[i].wen});
            end
            n_cmp++;
            if ({lb_raddr, lb_waddr, lb_wdata, lb_write_width} !==
                {tbl[i].raddr, tbl[i].waddr, tbl[i].wdata, tbl[i].width}) begin
               n_bad++;
               $display("FAIL dir%0d_latched: got %h %h %h %0d want %h %h %h %0d", i,
                        lb_raddr, lb_waddr, lb_wdata, lb_write_width,
                        tbl[i].raddr, tbl[i].waddr, tbl[i].wdata, tbl[i].width);
            end
         end
         tick;
         hb_ren = 1'b0; hb_wen = 1'b0;
         lb_finish = 1'b1; lb_rdata = tbl[i].rdata;
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen} !== 4'b1000) begin
            n_bad++;
            $display("FAIL dir%0d_finish_cycle: got stall/v/sel=%b want 1000", i,
                     {hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen});
         end
         tick;
         lb_finish = 1'b0; lb_rdata = $urandom;
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_resp_valid, hb_resp_err, hb_stall, hb_rdata} !== {3'b100, tbl[i].rdata}) begin
            n_bad++;
            $display("FAIL dir%0d_resp: got v/e/stall=%b rdata=%h want 100 rdata=%h", i,
                     {hb_resp_valid, hb_resp_err, hb_stall}, hb_rdata, tbl[i].rdata);
         end
         tick;
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_resp_valid, lb_sel_ren, lb_sel_wen} !== 3'b000) begin
            n_bad++;
            $display("FAIL dir%0d_single_resp: got v/sel=%b want 000", i,
                     {hb_resp_valid, lb_sel_ren, lb_sel_wen});
         end
      end
   endtask

   task automatic test_miss;
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_4000;
      hb_wen = 1'b1; hb_waddr = 32'h0000_9000;
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen} !== 4'b0000) begin
            n_bad++;
            $display("FAIL miss_cycle%0d: got stall/v/sel=%b want 0000", k,
                     {hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen});
         end
         tick;
      end
      clear_inputs;
   endtask

`ifdef XT_LB_TIMEOUT_EN
   task automatic test_timeout;
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8000;
      tick;
      hb_ren = 1'b0;
      for (int unsigned k = 1; k <= TMO + 1; k++) begin
         @(negedge hb_clk);
         n_cmp++;
         if ({lb_sel_ren, hb_resp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL tmo_wait%0d: got sel/v=%b want 10", k, {lb_sel_ren, hb_resp_valid});
         end
         tick;
      end
      @(negedge hb_clk);
      n_cmp++;
      if ({hb_resp_valid, hb_resp_err, hb_stall, hb_rdata} !== {3'b110, 32'h0}) begin
         n_bad++;
         $display("FAIL tmo_resp: got v/e/stall=%b rdata=%h want 110 rdata=0",
                  {hb_resp_valid, hb_resp_err, hb_stall}, hb_rdata);
      end
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8020;
      for (int unsigned k = 0; k < 3; k++) begin
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_stall, hb_resp_valid, lb_sel_ren} !== 3'b100) begin
            n_bad++;
            $display("FAIL drain_stall%0d: got stall/v/sel=%b want 100", k,
                     {hb_stall, hb_resp_valid, lb_sel_ren});
         end
         tick;
      end
      lb_finish = 1'b1; lb_rdata = 32'hBAD0_BAD0;
      @(negedge hb_clk);
      n_cmp++;
      if ({hb_stall, hb_resp_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL drain_finish: got stall/v=%b want 10", {hb_stall, hb_resp_valid});
      end
      tick;
      lb_finish = 1'b0; lb_rdata = '0;
      tick;
      hb_ren = 1'b0;
      @(negedge hb_clk);
      n_cmp++;
      if ({lb_sel_ren, lb_raddr} !== {1'b1, 32'h0000_8020}) begin
         n_bad++;
         $display("FAIL after_drain_issue: got sel=%b raddr=%h want 1 8020", lb_sel_ren, lb_raddr);
      end
      tick;
      lb_finish = 1'b1; lb_rdata = 32'h1111_2222;
      tick;
      lb_finish = 1'b0; lb_rdata = '0;
      @(negedge hb_clk);
      n_cmp++;
      if ({hb_resp_valid, hb_resp_err, hb_rdata} !== {2'b10, 32'h1111_2222}) begin
         n_bad++;
         $display("FAIL after_drain_resp: got v/e=%b rdata=%h want 10 11112222",
                  {hb_resp_valid, hb_resp_err}, hb_rdata);
      end
      // finish arriving in the very cycle the watchdog expires
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8040;
      tick;
      hb_ren = 1'b0;
      repeat (TMO) tick;
      lb_finish = 1'b1; lb_rdata = 32'h7777_8888;
      tick;
      lb_finish = 1'b0; lb_rdata = '0;
      @(negedge hb_clk);
      n_cmp++;
      if ({hb_resp_valid, hb_resp_err, hb_rdata} !== {2'b10, 32'h7777_8888}) begin
         n_bad++;
         $display("FAIL coincide_resp: got v/e=%b rdata=%h want 10 77778888",
                  {hb_resp_valid, hb_resp_err}, hb_rdata);
      end
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8044;
      tick;
      hb_ren = 1'b0;
      @(negedge hb_clk);
      n_cmp++;
      if (lb_sel_ren !== 1'b1) begin
         n_bad++;
         $display("FAIL coincide_no_drain: got sel_ren=%b want 1", lb_sel_ren);
      end
      tick;
      lb_finish = 1'b1;
      tick;
      lb_finish = 1'b0;
      tick;
   endtask
`endif

   task automatic test_reset_mid;
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8100; hb_wdata = 32'hFFFF_FFFF;
      tick;
      hb_ren = 1'b0;
      tick;
      rst_sync = 1'b1;
      #1;
      n_cmp++;
      if ({hb_stall, hb_resp_valid, hb_resp_err, lb_sel_ren, lb_sel_wen, hb_rdata, lb_raddr, lb_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got stall/v/e/sel=%b rdata=%h raddr=%h want all 0",
                  {hb_stall, hb_resp_valid, hb_resp_err, lb_sel_ren, lb_sel_wen}, hb_rdata, lb_raddr);
      end
      #2;
      rst_sync = 1'b0;
      tick;
      hb_ren = 1'b1; hb_raddr = 32'h0000_8200;
      tick;
      hb_ren = 1'b0;
      @(negedge hb_clk);
      n_cmp++;
      if ({lb_sel_ren, lb_raddr} !== {1'b1, 32'h0000_8200}) begin
         n_bad++;
         $display("FAIL post_reset_issue: got sel=%b raddr=%h want 1 8200", lb_sel_ren, lb_raddr);
      end
      tick;
      lb_finish = 1'b1; lb_rdata = 32'h0BAD_CAFE;
      tick;
      lb_finish = 1'b0; lb_rdata = '0;
      @(negedge hb_clk);
      n_cmp++;
      if ({hb_resp_valid, hb_resp_err, hb_rdata} !== {2'b10, 32'h0BAD_CAFE}) begin
         n_bad++;
         $display("FAIL post_reset_resp: got v/e=%b rdata=%h want 10 0badcafe",
                  {hb_resp_valid, hb_resp_err}, hb_rdata);
      end
      tick;
   endtask

   task automatic test_random;
      logic        m_busy = 1'b0, m_resp = 1'b0, m_rerr = 1'b0, m_drain = 1'b0;
      logic        m_ren = 1'b0, m_wen = 1'b0;
      logic [31:0] m_rd = '0, m_raddr = '0, m_waddr = '0, m_wdata = '0;
      logic [1:0]  m_wid = '0;
      int unsigned waited = 0;
      logic        hr, hw, e_stall;
      for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
         tick;
         hb_ren   = ($urandom_range(0, 2) == 0);
         hb_wen   = ($urandom_range(0, 2) == 0);
         hb_raddr = ($urandom_range(0, 3) != 0) ? (BASE | ($urandom & 32'hFFF)) : $urandom;
         hb_waddr = ($urandom_range(0, 3) != 0) ? (BASE | ($urandom & 32'hFFF)) : $urandom;
         hb_wdata = $urandom;
         hb_write_width = 2'($urandom);
         lb_finish = ($urandom_range(0, 5) == 0);
         lb_rdata  = $urandom;
         hr = hb_ren & in_win(hb_raddr);
         hw = hb_wen & in_win(hb_waddr);
         e_stall = m_resp ? 1'b0 : (m_busy ? 1'b1 : (hr | hw));
         @(negedge hb_clk);
         n_cmp++;
         if ({hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen} !==
             {e_stall, m_resp, m_busy & m_ren & ~lb_finish, m_busy & m_wen & ~lb_finish}) begin
            n_bad++;
            $display("FAIL rand%0d_ctrl: got stall/v/sel=%b want %b", cyc,
                     {hb_stall, hb_resp_valid, lb_sel_ren, lb_sel_wen},
                     {e_stall, m_resp, m_busy & m_ren & ~lb_finish, m_busy & m_wen & ~lb_finish});
         end
         if (m_resp) begin
            n_cmp++;
            if ({hb_resp_err, hb_rdata} !== {m_rerr, m_rd}) begin
               n_bad++;
               $display("FAIL rand%0d_resp: got e=%b rdata=%h want e=%b rdata=%h", cyc,
                        hb_resp_err, hb_rdata, m_rerr, m_rd);
            end
         end
         if (m_busy) begin
            n_cmp++;
            if ({lb_raddr, lb_waddr, lb_wdata, lb_write_width} !== {m_raddr, m_waddr, m_wdata, m_wid}) begin
               n_bad++;
               $display("FAIL rand%0d_latched: got %h %h %h %0d want %h %h %h %0d", cyc,
                        lb_raddr, lb_waddr, lb_wdata, lb_write_width, m_raddr, m_waddr, m_wdata, m_wid);
            end
         end
         if (m_resp) begin
            m_resp = 1'b0;
            m_drain = m_rerr;
         end else if (m_busy) begin
            if (lb_finish) begin
               m_resp = 1'b1; m_rerr = 1'b0; m_rd = lb_rdata; m_busy = 1'b0;
            end
`ifdef XT_LB_TIMEOUT_EN
            else if (waited == TMO) begin
               m_resp = 1'b1; m_rerr = 1'b1; m_rd = '0; m_busy = 1'b0;
            end
`endif
            else waited++;
         end else if (m_drain) begin
            if (lb_finish) m_drain = 1'b0;
         end else if (hr | hw) begin
            m_busy = 1'b1; waited = 0;
            m_ren = hr; m_wen = hw;
            m_raddr = hb_raddr; m_waddr = hb_waddr; m_wdata = hb_wdata; m_wid = hb_write_width;
         end
      end
   endtask

   initial begin
      rst_sync = 1'b1;
      clear_inputs;
      test_reset;
      test_directed;
      test_miss;
`ifdef XT_LB_TIMEOUT_EN
      test_timeout;
`endif
      test_reset_mid;
      clear_inputs;
      tick;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
